// File: rtl/imem_arbiter.sv
// Instruction-memory port arbiter: boot/halt loader writes, fetch reads in RUN with bounded loader wait.
// Optional IMEM_ALIGN_CHECK_EN: misaligned fetches return NOP_INSTR with if_err, misaligned loader writes are dropped.
module imem_arbiter #(
  parameter int          ADDR_W    = 12,
  parameter int          MAX_WAIT  = 8,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              ld_valid,
  input  logic [31:0]       ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic              ld_ready,
  input  logic              ld_halt,
  input  logic              ld_done,
  output logic              cpu_run,
  output logic              cpu_rst_pulse,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [1:0]        state_o
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  // Handshakes: a fetch is transferred in any cycle with if_req && if_gnt, a
  // loader write in any cycle with ld_valid && ld_ready; both grants are
  // combinational and never asserted together.

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                if_valid_q, if_valid_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic                if_err_q, if_err_d;
  logic                cpu_run_q, cpu_run_d;
  logic                cpu_rst_pulse_q, cpu_rst_pulse_d;
  logic                wait_max;
  logic                if_misalign;
  logic                ld_misalign;

  assign wait_max = (wait_cnt_q == WAIT_W'(MAX_WAIT));

`ifdef IMEM_ALIGN_CHECK_EN
  assign if_misalign = |if_addr[1:0];
  assign ld_misalign = |ld_addr[1:0];
`else
  assign if_misalign = 1'b0;
  assign ld_misalign = 1'b0;
`endif

  // Bits beyond the word index wrap; low bits only matter with the align check.
  logic unused_bits;
  assign unused_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                         ld_addr[31:ADDR_W+2], ld_addr[1:0], NOP_INSTR};

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    if_gnt     = 1'b0;
    ld_ready   = 1'b0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    // Port drives are gated by rst_n so a reset aborts a write immediately.
    if (rst_n) begin
      case (state_q)
        BOOT, HALT: begin
          ld_ready = ld_valid;
          if (ld_valid && !ld_misalign) begin
            mem_addr  = ld_addr[ADDR_W+1:2];
            mem_we    = 1'b1;
            mem_wdata = ld_wdata;
          end
          if (ld_done) state_d = RUN;
        end
        RUN: begin
          if (ld_halt) begin
            state_d = HALT;
          end else begin
            if_gnt   = if_req & ~wait_max;
            ld_ready = ld_valid & (~if_req | wait_max);
            if (ld_ready) begin
              if (!ld_misalign) begin
                mem_addr  = ld_addr[ADDR_W+1:2];
                mem_we    = 1'b1;
                mem_wdata = ld_wdata;
              end
            end else if (if_gnt) begin
              mem_addr = if_addr[ADDR_W+1:2];
            end
            if (ld_valid && !ld_ready)
              wait_cnt_d = wait_max ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_comb begin
    if_valid_d      = if_gnt;
    if_err_d        = if_gnt & if_misalign;
    if_rdata_d      = if_rdata_q;
    if (if_gnt) if_rdata_d = if_misalign ? NOP_INSTR : mem_rdata;
    cpu_run_d       = (state_d == RUN);
    cpu_rst_pulse_d = (state_d == RUN) && (state_q != RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= BOOT;
      wait_cnt_q      <= '0;
      if_valid_q      <= 1'b0;
      if_rdata_q      <= '0;
      if_err_q        <= 1'b0;
      cpu_run_q       <= 1'b0;
      cpu_rst_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      wait_cnt_q      <= wait_cnt_d;
      if_valid_q      <= if_valid_d;
      if_rdata_q      <= if_rdata_d;
      if_err_q        <= if_err_d;
      cpu_run_q       <= cpu_run_d;
      cpu_rst_pulse_q <= cpu_rst_pulse_d;
    end
  end

  assign if_valid      = if_valid_q;
  assign if_rdata      = if_rdata_q;
  assign if_err        = if_err_q;
  assign cpu_run       = cpu_run_q;
  assign cpu_rst_pulse = cpu_rst_pulse_q;
  assign state_o       = state_q;

  a_excl_grant: assert property (@(posedge clk) disable iff (!rst_n) !(if_gnt && ld_ready));
  a_no_we_on_fetch: assert property (@(posedge clk) disable iff (!rst_n) !(if_gnt && mem_we));

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Owns the single instruction-memory port. Shares it between the pipeline fetch stage, which reads, and a program loader, which writes over the debug/UART path.
- Sequences boot: the CPU is held until the loader finishes writing the program. Afterwards fetch has priority, with bounded-wait fairness for loader writes.
- Sits between the fetch stage and the word-addressed, combinational-read instruction memory.

Parameters:
ADDR_W, 12, word-index width driven to the memory (4096 words)
MAX_WAIT, 8, loader-starvation limit in cycles while in RUN
NOP_INSTR, 32'h00000013, instruction returned on a faulted fetch

Ports:
clk  in  1  clock; all state updates on its rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch requests a read this cycle
if_addr  in  32  byte address; word index is if_addr[ADDR_W+1:2]
if_gnt  out  1  fetch request accepted this cycle (combinational)
if_valid  out  1  registered; instruction data valid
if_rdata  out  32  registered instruction
if_err  out  1  registered; fault flag paired with if_valid
ld_valid  in  1  loader write request
ld_addr  in  32  loader byte address
ld_wdata  in  32  loader write data
ld_ready  out  1  loader write accepted this cycle (combinational)
ld_halt  in  1  request to re-enter load mode from RUN
ld_done  in  1  loader finished; single-cycle pulse
cpu_run  out  1  registered; 1 = core may execute
cpu_rst_pulse  out  1  registered; one-cycle pulse restarting the core PC
mem_addr  out  ADDR_W  memory word index
mem_we  out  1  memory write enable
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory combinational read data

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=BOOT, wait_cnt=0.
  - if_valid=0, if_rdata=0, if_err=0, cpu_run=0, cpu_rst_pulse=0.
- States: BOOT, RUN, HALT.
- BOOT:
  - if_gnt=0.
  - ld_ready=ld_valid.
  - On ld_valid: mem_addr=ld_addr[ADDR_W+1:2], mem_we=1, mem_wdata=ld_wdata.
  - ld_done -> RUN next cycle. On that edge cpu_run<=1 and cpu_rst_pulse<=1 for exactly one cycle.
  - A write presented in the same cycle as ld_done is still performed.
- RUN, default grant:
  - if_gnt=if_req.
  - ld_ready=ld_valid & (~if_req | wait_cnt==MAX_WAIT).
- RUN, fetch-granted cycle:
  - mem_addr=if_addr[ADDR_W+1:2], mem_we=0.
  - Next edge: if_valid<=1, if_rdata<=mem_rdata. Latency is 1 cycle from grant to data.
  - Cycles without a grant: if_valid<=0, if_rdata holds its value.
- RUN, starvation counter:
  - wait_cnt increments each cycle ld_valid=1 and ld_ready=0, saturating at MAX_WAIT.
  - It clears on any ld_ready=1 or when ld_valid=0.
  - When wait_cnt==MAX_WAIT, the loader wins: if_gnt=0 that cycle and the fetch stage must stall.
- RUN exits:
  - ld_halt=1 -> HALT next cycle. On that edge cpu_run<=0 and if_valid<=0.
  - ld_halt has priority over fetch in its cycle: if_gnt=0, ld_ready=0.
- HALT:
  - Same as BOOT, except it is entered from RUN.
  - ld_done -> RUN, with cpu_rst_pulse identical to BOOT exit.
- Ignored pulses:
  - ld_done while in RUN is ignored.
  - ld_halt while in BOOT or HALT is ignored.
- Mutual exclusion: mem_we=0 whenever if_gnt=1. if_gnt and ld_ready are never both 1.
- Address width: upper address bits above ADDR_W+1 are ignored, so addresses wrap modulo 4<<ADDR_W bytes.
- Idle outputs: when nothing is granted, mem_addr=0, mem_we=0, mem_wdata=0.
- Reset mid-operation: aborts any write in progress (mem_we drops asynchronously) and returns to BOOT.

Optional Feature:
IMEM_ALIGN_CHECK_EN
- Defined:
  - A granted fetch with if_addr[1:0]!=0 still consumes the grant.
  - Next cycle: if_valid=1, if_rdata=NOP_INSTR, if_err=1.
  - Loader writes with ld_addr[1:0]!=0 are accepted (ld_ready=1) but dropped (mem_we=0).
- Undefined:
  - Low address bits are ignored.
  - if_err is tied to 0.

Test Plan:
- Boot load: write 0x00500093 to addr 0x0, 0x00108113 to addr 0x4, pulse ld_done -> mem_we seen twice; next cycle cpu_run=1 and cpu_rst_pulse=1 for one cycle only; if_gnt=0 throughout BOOT.
- Fetch latency: RUN, if_req=1, if_addr=0x4 -> if_gnt=1 same cycle; next cycle if_valid=1, if_rdata=0x00108113.
- Starvation: RUN, if_req held 1, ld_valid held 1 -> ld_ready=0 for MAX_WAIT=8 cycles; 9th cycle ld_ready=1, if_gnt=0, mem_we=1; following cycle fetch regains the grant.
- Halt/reload: in RUN assert ld_halt -> cpu_run=0 next cycle; write 0xDEADBEEF at 0x8, ld_done -> cpu_rst_pulse; fetch 0x8 returns 0xDEADBEEF.
- Async reset: drop rst_n mid-write in HALT -> mem_we=0 immediately, state BOOT, all registered outputs 0.
- With IMEM_ALIGN_CHECK_EN: fetch if_addr=0x6 -> next cycle if_valid=1, if_err=1, if_rdata=0x00000013; without the macro: if_err=0, if_rdata=word at 0x4.
